// File: rtl/bram_fifo.sv
// ---------------------------------------------------------------------------
// bram_fifo
//
// FIFO controller built around an external BRAM that has one write port and
// one read port with a registered (one-cycle) read. It turns the BRAM's
// address/registered-data interface into an enq/first/deq method interface.
// Entries sit in the BRAM until they are pulled into a single head register
// ("first"). There is one read in flight at most at any time.
//
// Parameters
//   depth : number of BRAM entries (>= 2, any value)
//   width : data width in bits (must match the attached BRAM)
//
// Ports
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   enq__ENA/enq_v/enq__RDY   enqueue strobe, data, space available
//   deq__ENA/deq__RDY         dequeue strobe, head valid (same as first__RDY)
//   first/first__RDY          head-of-queue data register and its valid flag
//   count                     total entries held (BRAM + in-flight + head)
//   bram_write_*              BRAM write strobe/address/data, write ready
//   bram_read_*               BRAM read strobe/address, read ready
//   bram_dataOut, __RDY       BRAM read data, valid one cycle after a read
// ---------------------------------------------------------------------------
module bram_fifo #(
  parameter int depth = 1024,
  parameter int width = 4,
  localparam int aw = (depth > 1) ? $clog2(depth) : 1,
  localparam int cw = $clog2(depth + 3)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq__ENA,
  input  logic [width-1:0] enq_v,
  output logic             enq__RDY,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic [width-1:0] first,
  output logic             first__RDY,
  output logic [cw-1:0]    count,
  output logic             bram_write__ENA,
  output logic [aw-1:0]    bram_write_addr,
  output logic [width-1:0] bram_write_data,
  input  logic             bram_write__RDY,
  output logic             bram_read__ENA,
  output logic [aw-1:0]    bram_read_addr,
  input  logic             bram_read__RDY,
  input  logic [width-1:0] bram_dataOut,
  input  logic             bram_dataOut__RDY
);

  // State
  logic [aw-1:0]    wptr_reg, wptr_next;
  logic [aw-1:0]    rptr_reg, rptr_next;
  logic [cw-1:0]    cnt_reg, cnt_next;        // entries resident in the BRAM
  logic             rd_pend_reg, rd_pend_next; // read issued, data not yet captured
  logic             out_valid_reg, out_valid_next;
  logic [width-1:0] out_reg, out_next;

  logic enq_fire;
  logic deq_fire;
  logic rd_issue;

  // Pointer increment with wrap at depth-1 (depth need not be a power of two).
  function automatic logic [aw-1:0] bump(input logic [aw-1:0] p);
    return (p == aw'(depth - 1)) ? '0 : p + aw'(1);
  endfunction

  // Handshakes. Qualifying with nRST keeps every strobe/ready low while reset
  // is held, independent of the BRAM-side ready inputs.
  assign enq__RDY = nRST && (cnt_reg < cw'(depth)) && bram_write__RDY;
  assign enq_fire = enq__ENA && enq__RDY;
  assign deq_fire = deq__ENA && out_valid_reg;

  // Only one read may be outstanding; a new read is issued when the head
  // register is free or is being emptied this cycle.
  assign rd_issue = nRST && (cnt_reg != '0) && !rd_pend_reg && bram_read__RDY &&
                    (!out_valid_reg || deq__ENA);

  // BRAM client side
  assign bram_write__ENA = enq_fire;
  assign bram_write_addr = wptr_reg;
  assign bram_write_data = enq_v;
  assign bram_read__ENA  = rd_issue;
  assign bram_read_addr  = rptr_reg;

  // Method side
  assign first      = out_reg;
  assign first__RDY = out_valid_reg;
  assign deq__RDY   = out_valid_reg;
  assign count      = cnt_reg + cw'(rd_pend_reg) + cw'(out_valid_reg);

  always_comb begin
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    cnt_next       = cnt_reg;
    rd_pend_next   = rd_pend_reg;
    out_valid_next = out_valid_reg;
    out_next       = out_reg;

    if (enq_fire) begin
      wptr_next = bump(wptr_reg);
    end
    if (rd_issue) begin
      rptr_next = bump(rptr_reg);
    end

    case ({enq_fire, rd_issue})
      2'b10:   cnt_next = cnt_reg + cw'(1);
      2'b01:   cnt_next = cnt_reg - cw'(1);
      default: cnt_next = cnt_reg;
    endcase

    // The BRAM presents data exactly one cycle after the read, so a pending
    // read is always captured in the following cycle. Capture wins over a
    // simultaneous dequeue: the old head leaves, the new one arrives.
    if (rd_pend_reg) begin
      out_next       = bram_dataOut;
      out_valid_next = 1'b1;
      rd_pend_next   = 1'b0;
    end else if (deq_fire) begin
      out_valid_next = 1'b0;
    end

    // rd_issue requires !rd_pend_reg, so it never collides with the clear above.
    if (rd_issue) begin
      rd_pend_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      cnt_reg       <= '0;
      rd_pend_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      cnt_reg       <= cnt_next;
      rd_pend_reg   <= rd_pend_next;
      out_valid_reg <= out_valid_next;
      out_reg       <= out_next;
    end
  end

  // Protocol checks: strobes without ready are ignored by the logic above,
  // and the BRAM must deliver valid data in the cycle after every read.
  a_enq_protocol: assert property (@(posedge CLK) disable iff (!nRST)
    enq__ENA |-> enq__RDY);
  a_deq_protocol: assert property (@(posedge CLK) disable iff (!nRST)
    deq__ENA |-> deq__RDY);
  a_read_data_valid: assert property (@(posedge CLK) disable iff (!nRST)
    rd_pend_reg |-> bram_dataOut__RDY);

endmodule
